register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//  Parametrised multi-read-port integer register file with an integrated scoreboard.
//  Sits between decode (read, issue) and writeback (write) of the RISC-V core.
//  Read ports are registered (1-cycle latency), x0 reads as zero, and SP resets to the stack top.
//  Per-register busy bits track outstanding writes so decode can stall on RAW hazards.
// PARAMETERS
//  XLEN     32            data width in bits
//  NREGS    32            register count; must be a power of two, >= 2; AW = $clog2(NREGS)
//  NREAD    2             number of read ports, 1..4
//  SP_IDX   2             index loaded with SP_INIT on reset; must satisfy 0 < SP_IDX < NREGS
//  SP_INIT  32'h80000FFC  SP reset value, truncated to XLEN
// PORTS
//  clk         in   1           clock, rising edge
//  rst         in   1           asynchronous, active-high reset
//  r_en        in   1           read enable for all ports
//  rs_addr     in   NREAD*AW    read addresses; port k uses bits [k*AW +: AW]
//  rs_data     out  NREAD*XLEN  registered read data; port k uses bits [k*XLEN +: XLEN]
//  rs_busy     out  NREAD       registered busy flag of each read address
//  w_en        in   1           write enable
//  rd          in   AW          write address
//  write_data  in   XLEN        write data
//  iss_en      in   1           issue: mark iss_rd as pending
//  iss_rd      in   AW          destination register of the issued instruction
//  flush       in   1           clear all busy bits
//  busy_vec    out  NREGS       live (unregistered) scoreboard state; bit 0 is always 0
// BEHAVIOUR
//  - Reset (async assert, evaluated at posedge clk thereafter):
//    - regs = 0 except regs[SP_IDX] = SP_INIT.
//    - rs_data = 0, rs_busy = 0, busy_vec = 0.
//    - Reset asserted mid-operation aborts pending writes, issues and reads in that cycle.
//  - Write: at posedge, w_en & rd!=0 -> regs[rd] <= write_data. Writes to x0 are dropped.
//  - Read: at posedge, r_en=1 -> for each port k, capture regs[addr_k] into rs_data[k]
//    and busy[addr_k] into rs_busy[k].
//    - addr_k=0 -> data 0, busy 0.
//    - r_en=0 -> rs_data and rs_busy hold their previous values.
//    - Latency: address at edge N -> data valid after edge N.
//  - Scoreboard update at posedge:
//    - clear: w_en & rd!=0 -> busy[rd] <= 0
//    - set: iss_en & iss_rd!=0 -> busy[iss_rd] <= 1
//    - Set and clear on the same index in one cycle -> set wins (new producer).
//    - flush -> all busy <= 0, overriding both set and clear. Register writes still happen.
//  - Same-cycle read of an address being written (addr_k==rd, w_en, rd!=0):
//    - see CONFIGURATION.
//  - Same-cycle read of an address being issued: rs_busy reflects pre-issue state.
//  - Multiple ports may read the same address; each gets identical data and busy.
//  - No X propagation: all address bits are decoded in full, with no out-of-range indices.
// CONFIGURATION
//  RF_BYPASS_EN defined:
//    - Write-to-read forwarding. Port reading rd while w_en=1 captures write_data.
//    - Its rs_busy captures the post-clear state (0 unless re-issued the same cycle, then 1).
//  RF_BYPASS_EN undefined:
//    - Read-before-write. Port captures the old regs[rd] and the old busy bit.
//    - Pipeline must hold the reader one cycle.
// TESTING
//  1. Reset: pulse rst mid-cycle, then r_en with addrs {2,5} -> rs_data {32'h80000FFC, 0}; busy_vec=0.
//  2. Write x0: w_en, rd=0, data 32'hDEAD_BEEF; next cycle read addr 0 -> rs_data 0.
//  3. Write x7=32'h1234_5678, read x7 the same cycle:
//     - bypass build -> 32'h1234_5678
//     - plain build -> 0, then 32'h1234_5678 the next cycle
//  4. Scoreboard:
//     - issue x9 -> busy_vec[9]=1; read x9 -> rs_busy=1.
//     - write x9 and issue x9 in the same cycle -> busy_vec[9] stays 1.
//     - write x9 alone -> busy_vec[9]=0.
//  5. Flush: issue x3, x4, x5 on consecutive cycles, then flush together with issue x6 -> busy_vec=0.
//  6. Hold: r_en=0 while regs change -> rs_data and rs_busy unchanged.
//     - Sweep NREAD=1,4 and NREGS=16 with random write/read traffic against a reference model.

Source files
------------

// File: rtl/register_file_mp.sv
// register_file_mp
//   Multi-read-port integer register file with a built-in scoreboard. It sits
//   between decode (reads and issue) and writeback (writes) of the core. Read
//   ports are registered, so data appears one cycle after the address. x0
//   always reads as zero. The stack pointer register resets to the stack top.
//   A busy bit per register records an outstanding write, so decode can stall
//   on RAW hazards.
//
//   Build option: define RF_BYPASS_EN to enable write-to-read forwarding.
//   Without it, a port reading the register being written in the same cycle
//   gets the old value and the old busy bit (read-before-write).
//
// Parameters
//   XLEN     data width
//   NREGS    register count (power of two, >= 2), AW = $clog2(NREGS)
//   NREAD    number of read ports (1..4)
//   SP_IDX   register loaded with SP_INIT on reset (0 < SP_IDX < NREGS)
//   SP_INIT  stack pointer reset value, truncated to XLEN
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   r_en        read enable shared by all ports
//   rs_addr     read addresses, port k at [k*AW +: AW]
//   rs_data     registered read data, port k at [k*XLEN +: XLEN]
//   rs_busy     registered busy flag of each read address
//   w_en        write enable
//   rd          write address
//   write_data  write data
//   iss_en      issue: mark iss_rd as pending
//   iss_rd      destination register of the issued instruction
//   flush       clear all busy bits
//   busy_vec    live scoreboard state, bit 0 always 0
module register_file_mp #(
  parameter int          XLEN    = 32,
  parameter int          NREGS   = 32,
  parameter int          NREAD   = 2,
  parameter int          SP_IDX  = 2,
  parameter logic [31:0] SP_INIT = 32'h80000FFC
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                r_en,
  input  logic [NREAD*$clog2(NREGS)-1:0]      rs_addr,
  output logic [NREAD*XLEN-1:0]               rs_data,
  output logic [NREAD-1:0]                    rs_busy,
  input  logic                                w_en,
  input  logic [$clog2(NREGS)-1:0]            rd,
  input  logic [XLEN-1:0]                     write_data,
  input  logic                                iss_en,
  input  logic [$clog2(NREGS)-1:0]            iss_rd,
  input  logic                                flush,
  output logic [NREGS-1:0]                    busy_vec
);

  localparam int AW = $clog2(NREGS);
  localparam logic [XLEN-1:0] SP_RST = XLEN'(SP_INIT);

  generate
    if ((NREGS < 2) || ((1 << AW) != NREGS))
      $error("register_file_mp: NREGS must be a power of two >= 2");
    if ((NREAD < 1) || (NREAD > 4))
      $error("register_file_mp: NREAD must be 1..4");
    if ((SP_IDX <= 0) || (SP_IDX >= NREGS))
      $error("register_file_mp: SP_IDX must satisfy 0 < SP_IDX < NREGS");
  endgenerate

  logic [XLEN-1:0]       regs [NREGS];
  logic [NREGS-1:0]      busy;
  logic [NREGS-1:0]      busy_next;
  logic [NREAD*XLEN-1:0] rs_data_next;
  logic [NREAD-1:0]      rs_busy_next;
  logic [AW-1:0]         port_addr;

  logic write_hit;
  assign write_hit = w_en && (rd != '0);

  // Register storage. x0 is never written, so it stays at its reset value of 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == SP_IDX) ? SP_RST : '0;
    end else if (write_hit) begin
      regs[rd] <= write_data;
    end
  end

  // Scoreboard next state. A clear and a set of the same index in one cycle
  // means a new producer has issued, so the set is applied last and wins.
  // Flush overrides everything.
  always_comb begin
    busy_next = busy;
    if (write_hit)
      busy_next[rd] = 1'b0;
    if (iss_en && (iss_rd != '0))
      busy_next[iss_rd] = 1'b1;
    if (flush)
      busy_next = '0;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy <= '0;
    else
      busy <= busy_next;
  end

  assign busy_vec = busy;

  // Read ports. When r_en is low the outputs hold their values. With
  // forwarding enabled, a port that reads the register being written takes
  // write_data and the post-writeback busy bit. That bit is 1 only if the
  // register was re-issued in the same cycle. Other reads see the pre-edge
  // state, so an issue in the same cycle is not yet visible.
  always_comb begin
    rs_data_next = rs_data;
    rs_busy_next = rs_busy;
    port_addr    = '0;
    if (r_en) begin
      for (int k = 0; k < NREAD; k++) begin
        port_addr = rs_addr[k*AW +: AW];
        if (port_addr == '0) begin
          rs_data_next[k*XLEN +: XLEN] = '0;
          rs_busy_next[k]              = 1'b0;
        end
`ifdef RF_BYPASS_EN
        else if (write_hit && (rd == port_addr)) begin
          rs_data_next[k*XLEN +: XLEN] = write_data;
          rs_busy_next[k]              = busy_next[port_addr];
        end
`endif
        else begin
          rs_data_next[k*XLEN +: XLEN] = regs[port_addr];
          rs_busy_next[k]              = busy[port_addr];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_data <= '0;
      rs_busy <= '0;
    end else begin
      rs_data <= rs_data_next;
      rs_busy <= rs_busy_next;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp
//   Self-checking bench for register_file_mp. It runs directed scenarios first,
//   then random traffic. Each cycle, the DUT outputs are compared against a
//   behavioural model held in plain arrays.
module tb_register_file_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = $clog2(NREGS);
  localparam logic [XLEN-1:0] SP_VAL = 32'h80000FFC;
`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  r_en;
  logic [NREAD*AW-1:0]   rs_addr;
  logic [NREAD*XLEN-1:0] rs_data;
  logic [NREAD-1:0]      rs_busy;
  logic                  w_en;
  logic [AW-1:0]         rd;
  logic [XLEN-1:0]       write_data;
  logic                  iss_en;
  logic [AW-1:0]         iss_rd;
  logic                  flush;
  logic [NREGS-1:0]      busy_vec;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state
  logic [XLEN-1:0]       m_regs [NREGS];
  logic [NREGS-1:0]      m_busy;
  logic [NREAD*XLEN-1:0] m_data;
  logic [NREAD-1:0]      m_rbusy;

  always #5 clk = ~clk;

  register_file_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .SP_IDX(2), .SP_INIT(32'h80000FFC)
  ) dut (
    .clk(clk), .rst(rst), .r_en(r_en), .rs_addr(rs_addr), .rs_data(rs_data),
    .rs_busy(rs_busy), .w_en(w_en), .rd(rd), .write_data(write_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .busy_vec(busy_vec)
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".rs_data"}, rs_data, m_data);
    checkOutput({tag, ".rs_busy"}, rs_busy, m_rbusy);
    checkOutput({tag, ".busy_vec"}, busy_vec, m_busy);
  endtask

  task automatic modelReset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_regs[2] = SP_VAL;
    m_busy    = '0;
    m_data    = '0;
    m_rbusy   = '0;
  endtask

  // One clock edge of the architectural behaviour: reads see pre-edge state,
  // except forwarded reads, which see the value written and the scoreboard
  // after this edge.
  task automatic modelStep();
    logic [NREGS-1:0] after;
    int a;
    after = m_busy;
    if (w_en && rd != 0) after[rd] = 1'b0;
    if (iss_en && iss_rd != 0) after[iss_rd] = 1'b1;
    if (flush) after = '0;
    if (r_en) begin
      for (int k = 0; k < NREAD; k++) begin
        a = int'(rs_addr[k*AW +: AW]);
        if (a == 0) begin
          m_data[k*XLEN +: XLEN] = '0;
          m_rbusy[k] = 1'b0;
        end else if (BYPASS && w_en && int'(rd) == a) begin
          m_data[k*XLEN +: XLEN] = write_data;
          m_rbusy[k] = after[a];
        end else begin
          m_data[k*XLEN +: XLEN] = m_regs[a];
          m_rbusy[k] = m_busy[a];
        end
      end
    end
    if (w_en && rd != 0) m_regs[rd] = write_data;
    m_busy = after;
  endtask

  task automatic drive(input bit re, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input bit we, input logic [AW-1:0] wr, input logic [XLEN-1:0] wd,
                       input bit ie, input logic [AW-1:0] ir, input bit fl);
    r_en = re; rs_addr = {a1, a0};
    w_en = we; rd = wr; write_data = wd;
    iss_en = ie; iss_rd = ir; flush = fl;
  endtask

  task automatic applyStimulus(input string tag, input bit re, input logic [AW-1:0] a0,
                               input logic [AW-1:0] a1, input bit we, input logic [AW-1:0] wr,
                               input logic [XLEN-1:0] wd, input bit ie, input logic [AW-1:0] ir,
                               input bit fl);
    drive(re, a0, a1, we, wr, wd, ie, ir, fl);
    @(posedge clk);
    modelStep();
    #1;
    checkAll(tag);
  endtask

  // Reset asserted in mid-cycle and held across an edge, so whatever is
  // pending on the inputs at that edge must be discarded.
  task automatic resetPulse();
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    #1;
    checkAll("async_rst");
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0]   a0, a1, wr, ir;
    logic [XLEN-1:0] wd;
    bit re, we, ie, fl;

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkAll("reset");

    // Reset pulse that aborts a pending write, issue and read
    applyStimulus("pre_w7", 1, 2, 0, 1, 7, 32'h1111_1111, 1, 11, 0);
    drive(1, 7, 11, 1, 7, 32'h2222_2222, 1, 7, 0);
    resetPulse();
    applyStimulus("rst_read", 1, 2, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_sp", rs_data[31:0], 32'h80000FFC);
    checkOutput("rst_x5", rs_data[63:32], 32'h0);
    checkOutput("rst_busy", busy_vec, 32'h0);
    applyStimulus("rst_abort", 1, 7, 11, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_abort_data", rs_data, 64'h0);
    checkOutput("rst_abort_busy", rs_busy, 2'b00);

    // Writes to x0 are dropped
    applyStimulus("w_x0", 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0);
    applyStimulus("r_x0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_zero", rs_data, 64'h0);

    // Same-cycle write and read of x7
    applyStimulus("w_r_x7", 1, 7, 7, 1, 7, 32'h1234_5678, 0, 0, 0);
    checkOutput("x7_same", rs_data[31:0], BYPASS ? 32'h1234_5678 : 32'h0);
    applyStimulus("r_x7", 1, 7, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x7_next", rs_data[31:0], 32'h1234_5678);

    // Scoreboard set, set-wins, clear
    applyStimulus("iss9", 0, 0, 0, 0, 0, 0, 1, 9, 0);
    checkOutput("busy9_set", busy_vec[9], 1'b1);
    applyStimulus("r9", 1, 9, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rbusy9", rs_busy[0], 1'b1);
    applyStimulus("w_iss9", 0, 0, 0, 1, 9, 32'hA9A9_0001, 1, 9, 0);
    checkOutput("busy9_setwins", busy_vec[9], 1'b1);
    applyStimulus("w9", 0, 0, 0, 1, 9, 32'hA9A9_0002, 0, 0, 0);
    checkOutput("busy9_clr", busy_vec[9], 1'b0);

    // Flush overrides a same-cycle issue
    applyStimulus("iss3", 0, 0, 0, 0, 0, 0, 1, 3, 0);
    applyStimulus("iss4", 0, 0, 0, 0, 0, 0, 1, 4, 0);
    applyStimulus("iss5", 0, 0, 0, 0, 0, 0, 1, 5, 0);
    checkOutput("busy345", busy_vec, 32'h38);
    applyStimulus("flush", 0, 0, 0, 0, 0, 0, 1, 6, 1);
    checkOutput("flush_busy", busy_vec, 32'h0);

    // Hold with r_en low while state changes
    applyStimulus("iss7", 0, 0, 0, 0, 0, 0, 1, 7, 0);
    applyStimulus("r7_9", 1, 7, 9, 0, 0, 0, 0, 0, 0);
    applyStimulus("hold1", 0, 7, 9, 1, 7, 32'h7777_0000, 0, 0, 0);
    applyStimulus("hold2", 0, 9, 7, 1, 9, 32'h9999_0000, 1, 9, 0);
    checkOutput("hold_data", rs_data, {32'hA9A9_0002, 32'h1234_5678});
    checkOutput("hold_busy", rs_busy, 2'b01);

    // Random traffic, biased to low indices to provoke collisions and x0
    for (int n = 0; n < 400; n++) begin
      re = ($urandom_range(0, 3) != 0);
      a0 = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom);
      a1 = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom);
      we = $urandom_range(0, 1);
      wr = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom);
      wd = $urandom;
      ie = ($urandom_range(0, 9) < 3);
      ir = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom);
      fl = ($urandom_range(0, 19) == 0);
      applyStimulus("rand", re, a0, a1, we, wr, wd, ie, ir, fl);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
